rf_wb_arbiter: RTL and testbench

Writeback arbiter and pending-write scoreboard for the 32x32 register file's single write port (a3/we3/wd3). It shares that port between NREQ writeback sources (ALU, load unit, mul/div) using round-robin valid/ready arbitration and a registered output stage. It also tracks which destination registers have an issued-but-unwritten result, so decode can stall on RAW hazards.

---
 rtl/rf_wb_arbiter.sv | 107 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port, with a
// registered write stage and a pending-write scoreboard for RAW stall detection.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*5-1:0]    i_req_rd,
    input  logic [NREQ*XLEN-1:0] i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [4:0]           o_rf_a3,
    output logic                 o_rf_we3,
    output logic [XLEN-1:0]      o_rf_wd3,
    input  logic                 i_pend_set,
    input  logic [4:0]           i_pend_rd,
    input  logic                 i_flush,
    output logic [31:0]          o_pending
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTRW-1:0] r_ptr;
    logic [PTRW-1:0] w_ptr_nxt;
    logic [NREQ-1:0] w_grant;
    logic            w_grant_any;
    logic [PTRW-1:0] w_grant_idx;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic [31:1]     r_pend;
    logic [31:0]     w_pend_nxt;

    // Scan from the pointer, wrapping, and grant the first valid requester.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_grant_any && i_req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_grant_any = 1'b1;
                w_grant_idx = PTRW'((int'(r_ptr) + k) % NREQ);
            end
        end
        if (!rst_n) begin
            w_grant_any = 1'b0;
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign o_req_ready = w_grant;
    assign w_ptr_nxt   = (w_grant_idx == PTRW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = i_req_rd[5*i +: 5];
                w_sel_data = i_req_data[XLEN*i +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            o_rf_a3  <= '0;
            o_rf_we3 <= 1'b0;
            o_rf_wd3 <= '0;
        end else if (w_grant_any) begin
            r_ptr    <= w_ptr_nxt;
            o_rf_a3  <= w_sel_rd;
            o_rf_wd3 <= w_sel_data;
            o_rf_we3 <= (w_sel_rd != 5'd0);
        end else begin
            o_rf_we3 <= 1'b0;
        end
    end

    // A new producer outranks both the retiring write and a flush.
    always_comb begin
        w_pend_nxt = {r_pend, 1'b0};
        if (i_flush) begin
            w_pend_nxt = '0;
        end else if (o_rf_we3) begin
            w_pend_nxt[o_rf_a3] = 1'b0;
        end
        if (i_pend_set) begin
            w_pend_nxt[i_pend_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt[31:1];
        end
    end

    assign o_pending = {r_pend, 1'b0};

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed vectors push expected writes,
// a negedge monitor pops and compares every register file write.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ*5-1:0]    i_req_rd;
    logic [NREQ*XLEN-1:0] i_req_data;
    logic [NREQ-1:0]      o_req_ready;
    logic [4:0]           o_rf_a3;
    logic                 o_rf_we3;
    logic [XLEN-1:0]      o_rf_wd3;
    logic                 i_pend_set;
    logic [4:0]           i_pend_rd;
    logic                 i_flush;
    logic [31:0]          o_pending;

    logic [4:0]      rdTab   [NREQ];
    logic [XLEN-1:0] dataTab [NREQ];
    logic [36:0]     expQ    [$];
    int              nChecks = 0;
    int              nFails  = 0;

    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_valid(i_req_valid),
        .i_req_rd   (i_req_rd),
        .i_req_data (i_req_data),
        .o_req_ready(o_req_ready),
        .o_rf_a3    (o_rf_a3),
        .o_rf_we3   (o_rf_we3),
        .o_rf_wd3   (o_rf_wd3),
        .i_pend_set (i_pend_set),
        .i_pend_rd  (i_pend_rd),
        .i_flush    (i_flush),
        .o_pending  (o_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic packTables();
        for (int i = 0; i < NREQ; i++) begin
            i_req_rd[5*i +: 5]           = rdTab[i];
            i_req_data[XLEN*i +: XLEN]   = dataTab[i];
        end
    endtask

    // Called at posedge+1; drives one cycle of stimulus and returns at the next posedge+1.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] expReady,
                                 input logic set, input logic [4:0] setRd, input logic fl);
        packTables();
        i_req_valid = valid;
        i_pend_set  = set;
        i_pend_rd   = setRd;
        i_flush     = fl;
        #1;
        checkOutput("req_ready", 64'(o_req_ready), 64'(expReady));
        for (int i = 0; i < NREQ; i++) begin
            if (expReady[i] && rdTab[i] != 5'd0) begin
                expQ.push_back({rdTab[i], dataTab[i]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_rf_we3 === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_write: got a3=%0d wd3=%h, expected no write", o_rf_a3, o_rf_wd3);
            end else begin
                checkOutput("rf_write", 64'({o_rf_a3, o_rf_wd3}), 64'(expQ.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b1;
        rdTab[0]    = 5'd1;  dataTab[0] = 32'hA;
        rdTab[1]    = 5'd2;  dataTab[1] = 32'hB;
        rdTab[2]    = 5'd3;  dataTab[2] = 32'hC;
        packTables();
        i_req_valid = 3'b111;
        i_pend_set  = 1'b1;
        i_pend_rd   = 5'd5;
        i_flush     = 1'b0;
        #1 rst_n    = 1'b0;
        #2;
        checkOutput("reset_ready",   64'(o_req_ready), 64'd0);
        checkOutput("reset_we3",     64'(o_rf_we3),    64'd0);
        checkOutput("reset_a3",      64'(o_rf_a3),     64'd0);
        checkOutput("reset_wd3",     64'(o_rf_wd3),    64'd0);
        checkOutput("reset_pending", 64'(o_pending),   64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_pending", 64'(o_pending), 64'd0);
        i_pend_set = 1'b0;
        rst_n      = 1'b1;

        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'b111, 3'(1 << (k % 3)), 1'b0, 5'd0, 1'b0);
        end

        rdTab[1] = 5'd0; dataTab[1] = 32'hDEADBEEF;
        applyStimulus(3'b010, 3'b010, 1'b0, 5'd0, 1'b0);
        rdTab[1] = 5'd2; dataTab[1] = 32'hB;
        applyStimulus(3'b110, 3'b100, 1'b0, 5'd0, 1'b0);

        applyStimulus(3'b000, 3'b000, 1'b1, 5'd5, 1'b0);
        checkOutput("pend5_set", 64'(o_pending), 64'(32'h1 << 5));
        rdTab[0] = 5'd5; dataTab[0] = 32'h55;
        applyStimulus(3'b001, 3'b001, 1'b0, 5'd0, 1'b0);
        checkOutput("pend5_we_cycle", 64'(o_pending), 64'(32'h1 << 5));
        applyStimulus(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);
        checkOutput("pend5_cleared", 64'(o_pending), 64'd0);

        applyStimulus(3'b000, 3'b000, 1'b1, 5'd7, 1'b0);
        checkOutput("pend7_set", 64'(o_pending), 64'(32'h1 << 7));
        rdTab[0] = 5'd7; dataTab[0] = 32'h77;
        applyStimulus(3'b001, 3'b001, 1'b0, 5'd0, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b1, 5'd7, 1'b0);
        checkOutput("pend7_collision", 64'(o_pending), 64'(32'h1 << 7));
        applyStimulus(3'b000, 3'b000, 1'b1, 5'd0, 1'b0);
        checkOutput("pend_x0_ignored", 64'(o_pending), 64'(32'h1 << 7));

        applyStimulus(3'b000, 3'b000, 1'b1, 5'd3, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b1, 5'd9, 1'b0);
        checkOutput("pend_3_7_9", 64'(o_pending), 64'(32'h288));
        rdTab[0] = 5'd3; dataTab[0] = 32'h33;
        applyStimulus(3'b001, 3'b001, 1'b1, 5'd4, 1'b1);
        checkOutput("flush_keeps_set", 64'(o_pending), 64'(32'h1 << 4));
        applyStimulus(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);
        checkOutput("flush_after_write", 64'(o_pending), 64'(32'h1 << 4));

        rdTab[2] = 5'd10; dataTab[2] = 32'hAA;
        applyStimulus(3'b100, 3'b100, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_we3",     64'(o_rf_we3),    64'd0);
        checkOutput("midreset_a3",      64'(o_rf_a3),     64'd0);
        checkOutput("midreset_pending", 64'(o_pending),   64'd0);
        checkOutput("midreset_ready",   64'(o_req_ready), 64'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(3'b110, 3'b010, 1'b0, 5'd0, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);

        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
